// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller slice.
package irq_pkg;

    localparam int          N_IRQ_MAX           = 32;
    localparam logic [31:0] MCAUSE_BASE_DEFAULT = 32'h8000_0010;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIN
    } irq_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 32,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [N-1:0]   upper;
    logic [2*N-1:0] dbl;

    always_comb begin
        upper = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = req[i] && (i > int'(ptr));
        end
    end

    // Low half holds only requests above ptr, so it wins; high half is the wrapped copy.
    assign dbl = {req, upper};

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl[i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'((i >= N) ? i - N : i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: masks level requests, arbitrates round-robin, holds one
// interrupt toward the core until mret, then pulses finish to the serviced device.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          N_IRQ       = 32,
    parameter logic [31:0] MCAUSE_BASE = MCAUSE_BASE_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] int_req_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             int_rst_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] int_fin_o,
    output logic             error_o
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_t       state, state_n;
    logic [IW-1:0]    ptr, ptr_n;
    logic [IW-1:0]    idx, idx_n;
    logic             int_n;
    logic [31:0]      mcause_n;
    logic [N_IRQ-1:0] fin_n;
    logic             err_n;
    logic [N_IRQ-1:0] pending;
    logic             gnt_valid;
    logic [IW-1:0]    gnt_idx;

    assign pending = int_req_i & mie_i;

    rr_arbiter #(.N(N_IRQ), .IW(IW)) u_arb (
        .req       (pending),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            ptr       <= IW'(N_IRQ - 1);
            idx       <= '0;
            int_o     <= 1'b0;
            mcause_o  <= '0;
            int_fin_o <= '0;
            error_o   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            idx       <= idx_n;
            int_o     <= int_n;
            mcause_o  <= mcause_n;
            int_fin_o <= fin_n;
            error_o   <= err_n;
        end
    end

    // mret outside BUSY is a protocol violation and latches the sticky error.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        idx_n    = idx;
        int_n    = int_o;
        mcause_n = mcause_o;
        fin_n    = '0;
        err_n    = error_o;
        case (state)
            IDLE: begin
                if (int_rst_i) err_n = 1'b1;
                if (gnt_valid) begin
                    state_n  = BUSY;
                    idx_n    = gnt_idx;
                    int_n    = 1'b1;
                    mcause_n = MCAUSE_BASE + 32'(gnt_idx);
                end
            end
            BUSY: begin
                if (int_rst_i) begin
                    state_n = FIN;
                    int_n   = 1'b0;
                    fin_n   = N_IRQ'(1) << idx;
                    ptr_n   = idx;
                end
            end
            FIN: begin
                if (int_rst_i) err_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
